// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel widths, brightness helper and scan states
package img_pkg;

  localparam int PIXEL_W = 24;
  localparam int BRIGHT_W = 10;
  localparam logic [BRIGHT_W-1:0] BRIGHT_INIT = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    SCAN     = 2'd2,
    REPORT   = 2'd3
  } state_e;

  // Each channel is widened before the sum, so 765 fits without wrap.
  function automatic logic [BRIGHT_W-1:0] brightness(input logic [PIXEL_W-1:0] p);
    return BRIGHT_W'(p[23:16]) + BRIGHT_W'(p[15:8]) + BRIGHT_W'(p[7:0]);
  endfunction

endpackage

// File: rtl/min_pixel_tracker.sv
// rtl/min_pixel_tracker.sv - keeps the darkest pixel seen and where it was
module min_pixel_tracker
  import img_pkg::*;
#(
  parameter int COL_W = 11,
  parameter int ROW_W = 10
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load_i,
  input  logic                update_i,
  input  logic [PIXEL_W-1:0]  pixel_i,
  input  logic [COL_W-1:0]    x_i,
  input  logic [ROW_W-1:0]    y_i,
  output logic [PIXEL_W-1:0]  min_pixel_o,
  output logic [COL_W-1:0]    min_x_o,
  output logic [ROW_W-1:0]    min_y_o,
  output logic [BRIGHT_W-1:0] min_bright_o
);

  logic [PIXEL_W-1:0]  pixel_q;
  logic [COL_W-1:0]    x_q;
  logic [ROW_W-1:0]    y_q;
  logic [BRIGHT_W-1:0] bright_q;
  logic [BRIGHT_W-1:0] cand_bright;
  logic                take;

  assign cand_bright = brightness(pixel_i);
  // Strict compare: on a tie the earlier pixel stays.
  assign take = load_i || (update_i && (cand_bright < bright_q));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pixel_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      bright_q <= BRIGHT_INIT;
    end else if (take) begin
      pixel_q  <= pixel_i;
      x_q      <= x_i;
      y_q      <= y_i;
      bright_q <= cand_bright;
    end
  end

  assign min_pixel_o  = pixel_q;
  assign min_x_o      = x_q;
  assign min_y_o      = y_q;
  assign min_bright_o = bright_q;

endmodule

// File: rtl/frame_min_scan_ctrl.sv
// rtl/frame_min_scan_ctrl.sv - frame-locked darkest-pixel scan with valid/ready result
module frame_min_scan_ctrl
  import img_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int COL_W  = 11,
  parameter int ROW_W  = 10
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                continuous,
  input  logic [PIXEL_W-1:0]  s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tuser,
  input  logic                s_tlast,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PIXEL_W-1:0]  res_pixel,
  output logic [COL_W-1:0]    res_x,
  output logic [ROW_W-1:0]    res_y,
  output logic [BRIGHT_W-1:0] res_bright,
  output logic                frame_err,
  output logic                busy
);

  localparam logic [COL_W-1:0] X_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(HEIGHT - 1);

  state_e             state_q;
  logic [COL_W-1:0]   x_q, x_d;
  logic [ROW_W-1:0]   y_q, y_d;
  logic               res_valid_q;
  logic               frame_err_q;

  logic               beat;
  logic               take;
  logic               trk_load;
  logic               trk_update;
  logic [COL_W-1:0]   beat_x;
  logic [ROW_W-1:0]   beat_y;
  logic               line_err;
  logic               frame_done;

  logic [PIXEL_W-1:0]  trk_pixel;
  logic [COL_W-1:0]    trk_x;
  logic [ROW_W-1:0]    trk_y;
  logic [BRIGHT_W-1:0] trk_bright;

  assign s_tready = (state_q != REPORT);
  assign beat     = s_tvalid && s_tready;

  // A start-of-frame beat always counts as (0,0), whatever the counters hold.
  always_comb begin
    take       = 1'b0;
    trk_load   = 1'b0;
    trk_update = 1'b0;
    beat_x     = x_q;
    beat_y     = y_q;
    if (beat && (state_q == WAIT_SOF || state_q == SCAN)) begin
      if (s_tuser) begin
        take     = 1'b1;
        trk_load = 1'b1;
        beat_x   = '0;
        beat_y   = '0;
      end else if (state_q == SCAN) begin
        take       = 1'b1;
        trk_update = 1'b1;
      end
    end
  end

  always_comb begin
    line_err   = 1'b0;
    frame_done = 1'b0;
    x_d        = (beat_x == X_LAST) ? beat_x : beat_x + COL_W'(1);
    y_d        = beat_y;
    if (s_tlast) begin
      line_err   = (beat_x != X_LAST);
      frame_done = (beat_y == Y_LAST);
      x_d        = '0;
      y_d        = frame_done ? '0 : beat_y + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      res_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_q <= WAIT_SOF;
        end
        WAIT_SOF, SCAN: begin
          if (take) begin
            x_q         <= x_d;
            y_q         <= y_d;
            frame_err_q <= line_err || (state_q == SCAN && s_tuser);
            if (frame_done) begin
              state_q     <= REPORT;
              res_valid_q <= 1'b1;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= continuous ? WAIT_SOF : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  min_pixel_tracker #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_tracker (
    .clk          (clk),
    .resetn       (resetn),
    .load_i       (trk_load),
    .update_i     (trk_update),
    .pixel_i      (s_tdata),
    .x_i          (beat_x),
    .y_i          (beat_y),
    .min_pixel_o  (trk_pixel),
    .min_x_o      (trk_x),
    .min_y_o      (trk_y),
    .min_bright_o (trk_bright)
  );

  // The tracker idles at the all-ones sentinel; the port shows zero until a result exists.
  assign res_valid  = res_valid_q;
  assign res_pixel  = res_valid_q ? trk_pixel  : '0;
  assign res_x      = res_valid_q ? trk_x      : '0;
  assign res_y      = res_valid_q ? trk_y      : '0;
  assign res_bright = res_valid_q ? trk_bright : '0;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_frame_min_scan_ctrl.sv
// tb/tb_frame_min_scan_ctrl.sv - directed self-checking bench on a 4x2 frame
module tb_frame_min_scan_ctrl;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        continuous;
  logic [23:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tuser;
  logic        s_tlast;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_pixel;
  logic [10:0] res_x;
  logic [9:0]  res_y;
  logic [9:0]  res_bright;
  logic        frame_err;
  logic        busy;

  int tests = 0;
  int failed = 0;
  int err_cnt = 0;
  int err_base;

  always #5 clk = ~clk;

  frame_min_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .COL_W(11), .ROW_W(10)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .continuous (continuous),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tuser    (s_tuser),
    .s_tlast    (s_tlast),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_pixel  (res_pixel),
    .res_x      (res_x),
    .res_y      (res_y),
    .res_bright (res_bright),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [23:0] d, input logic user, input logic last);
    @(negedge clk);
    s_tdata  = d;
    s_tuser  = user;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic release_result();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  logic [23:0] frame [8];

  initial begin
    resetn = 1'b0; start = 1'b0; continuous = 1'b0; res_ready = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd1);
    chk("rst_bright", 32'(res_bright), 32'd0);
    resetn = 1'b1;

    // Single dark pixel at (2,1)
    for (int i = 0; i < 8; i++) frame[i] = 24'h808080;
    frame[6] = 24'h010203;
    err_base = err_cnt;
    pulse_start();
    chk("t1_busy_armed", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        @(negedge clk);
        chk("t1_no_early_valid", 32'(res_valid), 32'd0);
      end
      send_beat(frame[i], i == 0, (i % W) == W - 1);
    end
    @(negedge clk);
    chk("t1_valid_lat1", 32'(res_valid), 32'd1);
    chk("t1_pixel", 32'(res_pixel), 32'h010203);
    chk("t1_x", 32'(res_x), 32'd2);
    chk("t1_y", 32'(res_y), 32'd1);
    chk("t1_bright", 32'(res_bright), 32'd6);
    chk("t1_no_err", 32'(err_cnt - err_base), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_tready", 32'(s_tready), 32'd0);
      chk("hold_pixel", 32'(res_pixel), 32'h010203);
      chk("hold_xy", {11'd0, res_x, res_y}, {11'd0, 11'd2, 10'd1});
    end
    release_result();
    chk("t1_valid_drop", 32'(res_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Junk before SOF, then a tie between (1,0) and (3,1)
    for (int i = 0; i < 8; i++) frame[i] = 24'h808080;
    frame[1] = 24'h000000;
    frame[7] = 24'h000000;
    continuous = 1'b1;
    pulse_start();
    send_beat(24'h000000, 1'b0, 1'b0);
    send_beat(24'h000000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_beat(frame[i], i == 0, (i % W) == W - 1);
    @(negedge clk);
    chk("t2_valid", 32'(res_valid), 32'd1);
    chk("t2_x_earliest", 32'(res_x), 32'd1);
    chk("t2_y_earliest", 32'(res_y), 32'd0);
    chk("t2_bright", 32'(res_bright), 32'd0);
    release_result();
    chk("t2_rearm_busy", 32'(busy), 32'd1);
    chk("t2_rearm_tready", 32'(s_tready), 32'd1);
    chk("t2_valid_drop", 32'(res_valid), 32'd0);

    // Short row 0 (tlast at x=2), already re-armed
    continuous = 1'b0;
    err_base = err_cnt;
    send_beat(24'h404040, 1'b1, 1'b0);
    send_beat(24'h404040, 1'b0, 1'b0);
    send_beat(24'h404040, 1'b0, 1'b1);
    send_beat(24'h404040, 1'b0, 1'b0);
    send_beat(24'h404040, 1'b0, 1'b0);
    send_beat(24'h404040, 1'b0, 1'b0);
    send_beat(24'h000010, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_err_pulses", 32'(err_cnt - err_base), 32'd1);
    chk("t3_valid", 32'(res_valid), 32'd1);
    chk("t3_x", 32'(res_x), 32'd3);
    chk("t3_y", 32'(res_y), 32'd1);
    chk("t3_bright", 32'(res_bright), 32'd16);
    release_result();
    chk("t3_idle", 32'(busy), 32'd0);

    // Reset in the middle of a scan, then a clean frame
    pulse_start();
    send_beat(24'h000000, 1'b1, 1'b0);
    send_beat(24'h000000, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 8; i++) frame[i] = 24'h202020;
    frame[4] = 24'h101010;
    err_base = err_cnt;
    pulse_start();
    for (int i = 0; i < 8; i++) send_beat(frame[i], i == 0, (i % W) == W - 1);
    @(negedge clk);
    chk("t4_valid", 32'(res_valid), 32'd1);
    chk("t4_pixel", 32'(res_pixel), 32'h101010);
    chk("t4_x", 32'(res_x), 32'd0);
    chk("t4_y", 32'(res_y), 32'd1);
    chk("t4_bright", 32'(res_bright), 32'd48);
    chk("t4_no_err", 32'(err_cnt - err_base), 32'd0);
    release_result();
    chk("t4_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/frame_min_scan_ctrl.md
Name: frame_min_scan_ctrl

Overview:
Sequences darkest-pixel search over one video frame on a 24-bit RGB pixel stream. Locks to start-of-frame and counts column and row. Runs an internal minimum-brightness tracker that is cleared per frame and also records coordinates. Presents {pixel, x, y, brightness} on a valid/ready result port for the car-control software interface.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, lines per frame
COL_W, 11, column counter width (must hold WIDTH-1)
ROW_W, 10, row counter width (must hold HEIGHT-1)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
start  in  1  arm one scan (level sampled in IDLE)
continuous  in  1  1: re-arm automatically after each result
s_tdata  in  24  pixel {R[23:16],G[15:8],B[7:0]}
s_tvalid  in  1  pixel beat valid
s_tready  out  1  pixel beat accepted when s_tvalid&&s_tready
s_tuser  in  1  start-of-frame marker on the first beat
s_tlast  in  1  end-of-line marker
res_valid  out  1  result available
res_ready  in  1  result consumed
res_pixel  out  24  darkest pixel value
res_x  out  COL_W  column of darkest pixel
res_y  out  ROW_W  row of darkest pixel
res_bright  out  10  R+G+B of darkest pixel
frame_err  out  1  one-cycle pulse on framing violation
busy  out  1  state != IDLE

Behaviour:
- Reset (resetn=0 at a clk edge, including mid-frame): state=IDLE, counters=0, res_valid=0, frame_err=0, res_pixel/res_x/res_y=0, res_bright=0, tracker min brightness=10'h3FF.
- Brightness = zero-extended sum of the three 8-bit channels into 10 bits (max 765). No truncation.
- Beat = s_tvalid&&s_tready. s_tready=1 in every state except REPORT, where s_tready=0 (backpressure).
- IDLE: beats are discarded. start=1 -> WAIT_SOF.
- WAIT_SOF: beats without s_tuser are discarded. A beat with s_tuser=1 is pixel (0,0): the tracker is loaded unconditionally with it. State -> SCAN, x=1, y=0. If that beat also has s_tlast=1, apply SCAN end-of-line rules.
- SCAN, per beat: if brightness < tracked min (strict; ties keep the earliest pixel), store pixel, x, y, brightness.
  - No s_tlast: x increments, saturating at WIDTH-1.
  - s_tlast=1: pulse frame_err if x != WIDTH-1. Then x=0 and y increments.
  - s_tlast=1 with y==HEIGHT-1: state -> REPORT after the compare.
- SCAN, s_tuser=1 on a beat: pulse frame_err. Treat the beat as a new (0,0): reload the tracker and set x=1, y=0.
- REPORT: res_valid=1 starting the cycle after the final beat (latency 1). res_* outputs equal the tracked values and are stable while res_valid=1 && res_ready=0.
- REPORT, res_ready=1: next state is WAIT_SOF if continuous=1, else IDLE. res_valid deasserts that next cycle.
- start is ignored outside IDLE. Changes to continuous take effect only at the REPORT exit.
- frame_err is 1 cycle wide and does not stop the scan.

Decomposition:
- Shared package img_pkg:
  - PIXEL_W=24, BRIGHT_W=10, BRIGHT_INIT=10'h3FF
  - brightness function
  - state enum {IDLE, WAIT_SOF, SCAN, REPORT}
- Sub-module min_pixel_tracker:
  - Inputs: clk, resetn, load, update, pixel, x, y.
  - Outputs: min pixel, x, y, brightness.
  - Internal strict-less compare. load overrides compare.
- FSM, counters and result handshake live in frame_min_scan_ctrl.

Test Plan:
- 4x2 frame (WIDTH=4, HEIGHT=2), pixels all 0x808080 except (2,1)=0x010203 -> res_valid 1 cycle after the last beat. res_pixel=0x010203, res_x=2, res_y=1, res_bright=6. frame_err never set.
- Tie: (1,0) and (3,1) both 0x000000 -> res_x=1, res_y=0 (earliest wins).
- Hold res_ready=0 for 10 cycles in REPORT -> s_tready=0 and res_* stable. Then res_ready=1 with continuous=0 -> IDLE, busy=0.
- Two non-SOF beats before the SOF beat in WAIT_SOF -> both ignored. Coordinates are counted from the SOF beat.
- s_tlast at x=2 on row 0 of a 4-wide frame -> frame_err pulse. Row 1 starts at x=0, and the final result is still produced.
- Reset asserted mid-SCAN, then start plus a clean frame -> result reflects only the new frame. No stale minimum.
